// File: rtl/pong_input_cond.sv
// Button conditioning for the pong core: 2-FF sync, integrating debounce, rise pulse,
// and a per-frame latched view. Optional auto-repeat of held buttons: PONG_INPUT_AUTOREPEAT_EN.
module pong_input_cond #(
    parameter int N_BTN     = 6,
    parameter int DEB_BITS  = 16,
    parameter int REP_DELAY = 24,
    parameter int REP_RATE  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             frame_tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_frame,
    output logic [N_BTN-1:0] btn_frame_rise
);

    localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

    if (REP_RATE < 1 || REP_RATE > REP_DELAY || REP_DELAY > 63) begin : g_bad_rep_cfg
        $error("pong_input_cond: need 1 <= REP_RATE <= REP_DELAY <= 63");
    end

    logic [N_BTN-1:0]    sync1_q, sync1_d;
    logic [N_BTN-1:0]    sync2_q, sync2_d;
    logic [N_BTN-1:0]    level_q, level_d;
    logic [N_BTN-1:0]    rise_q, rise_d;
    logic [N_BTN-1:0]    pending_q, pending_d;
    logic [N_BTN-1:0]    frame_q, frame_d;
    logic [N_BTN-1:0]    frame_rise_q, frame_rise_d;
    logic [DEB_BITS-1:0] cnt_q [N_BTN];
    logic [DEB_BITS-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0]    rep_fire;

    // Debounce: the synchronised value must disagree with the level for MAX+1 consecutive clocks.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
    end

`ifdef PONG_INPUT_AUTOREPEAT_EN
    localparam logic [5:0] REP_FIRE_AT = 6'(REP_DELAY);
    localparam logic [5:0] REP_RELOAD  = 6'(REP_DELAY - REP_RATE);

    logic [5:0] hold_q [N_BTN];
    logic [5:0] hold_d [N_BTN];
    logic [5:0] hold_inc;

    // Hold counter counts frames with the button down; reload keeps repeats REP_RATE apart.
    always_comb begin
        rep_fire = '0;
        hold_inc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hold_d[i] = hold_q[i];
            hold_inc  = hold_q[i] + 6'd1;
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (frame_tick) begin
                if (hold_inc == REP_FIRE_AT) begin
                    rep_fire[i] = 1'b1;
                    hold_d[i]   = REP_RELOAD;
                end else begin
                    hold_d[i] = hold_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
        end
    end
`else
    assign rep_fire = '0;
`endif

    // A rise in the same cycle as frame_tick belongs to the frame that is closing.
    always_comb begin
        pending_d    = frame_tick ? '0 : (pending_q | rise_q);
        frame_d      = frame_tick ? level_q : frame_q;
        frame_rise_d = frame_tick ? (pending_q | rise_q | rep_fire) : frame_rise_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            pending_q    <= '0;
            frame_q      <= '0;
            frame_rise_q <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            pending_q    <= pending_d;
            frame_q      <= frame_d;
            frame_rise_q <= frame_rise_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level      = level_q;
    assign btn_rise       = rise_q;
    assign btn_frame      = frame_q;
    assign btn_frame_rise = frame_rise_q;

endmodule

// File: tb/tb_pong_input_cond.sv
// Bench for pong_input_cond with DEB_BITS=2 (MAX=3), REP_DELAY=4, REP_RATE=2.
// Expected output bundle is {level, rise, frame, frame_rise}.
module tb_pong_input_cond;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [5:0] btn_raw;
    logic [5:0] btn_level, btn_rise, btn_frame, btn_frame_rise;

    pong_input_cond #(
        .N_BTN(6), .DEB_BITS(2), .REP_DELAY(4), .REP_RATE(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_raw        (btn_raw),
        .frame_tick     (frame_tick),
        .btn_level      (btn_level),
        .btn_rise       (btn_rise),
        .btn_frame      (btn_frame),
        .btn_frame_rise (btn_frame_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  raw;
        logic        tick;
        int          n;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef PONG_INPUT_AUTOREPEAT_EN
    localparam logic [5:0] REP_D    = 6'h02;
    localparam logic [7:0] REP_MASK = 8'b1010_1001;
`else
    localparam logic [5:0] REP_D    = 6'h00;
    localparam logic [7:0] REP_MASK = 8'b0000_0001;
`endif

    function automatic logic [23:0] pk(logic [5:0] lvl, logic [5:0] rs, logic [5:0] frm, logic [5:0] fr);
        return {lvl, rs, frm, fr};
    endfunction

    task automatic add(logic [5:0] raw, logic tick, int n, logic [23:0] exp);
        vec_t v;
        v.raw = raw; v.tick = tick; v.n = n; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(string name);
        logic [23:0] got, want;
        got = {btn_level, btn_rise, btn_frame, btn_frame_rise};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %h but no expected value queued", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s @%0t: got lvl/rise/frm/frise %h want %h", name, $time, got, want);
            end
        end
    endtask

    // Called at posedge+1; drives inputs, waits one edge, compares.
    task automatic step(string name, logic [5:0] raw, logic tick, int n, logic [23:0] exp);
        for (int i = 0; i < n; i++) begin
            btn_raw    = raw;
            frame_tick = tick;
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            check(name);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; btn_raw = '0; frame_tick = 1'b0;
        #12;
        exp_q.push_back('0);
        check("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // debounce ch0 rise/fall, ch3 glitch, frame latch ch1, coincident ch2, multiple rises ch0
        add(6'h00, 0, 2, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h01, 0, 5, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h01, 0, 1, pk(6'h01, 6'h01, 6'h00, 6'h00));
        add(6'h01, 0, 2, pk(6'h01, 6'h00, 6'h00, 6'h00));
        add(6'h00, 0, 5, pk(6'h01, 6'h00, 6'h00, 6'h00));
        add(6'h00, 0, 1, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h08, 0, 3, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h00, 0, 6, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h00, 1, 1, pk(6'h00, 6'h00, 6'h00, 6'h01));
        add(6'h00, 0, 2, pk(6'h00, 6'h00, 6'h00, 6'h01));
        add(6'h00, 1, 1, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h02, 0, 5, pk(6'h00, 6'h00, 6'h00, 6'h00));
        add(6'h02, 0, 1, pk(6'h02, 6'h02, 6'h00, 6'h00));
        add(6'h02, 0, 9, pk(6'h02, 6'h00, 6'h00, 6'h00));
        add(6'h02, 1, 1, pk(6'h02, 6'h00, 6'h02, 6'h02));
        add(6'h02, 0, 5, pk(6'h02, 6'h00, 6'h02, 6'h02));
        add(6'h02, 1, 1, pk(6'h02, 6'h00, 6'h02, 6'h00));
        add(6'h06, 0, 5, pk(6'h02, 6'h00, 6'h02, 6'h00));
        add(6'h06, 0, 1, pk(6'h06, 6'h04, 6'h02, 6'h00));
        add(6'h06, 1, 1, pk(6'h06, 6'h00, 6'h06, 6'h04));
        add(6'h06, 0, 3, pk(6'h06, 6'h00, 6'h06, 6'h04));
        add(6'h06, 1, 1, pk(6'h06, 6'h00, 6'h06, REP_D));
        add(6'h07, 0, 5, pk(6'h06, 6'h00, 6'h06, REP_D));
        add(6'h07, 0, 1, pk(6'h07, 6'h01, 6'h06, REP_D));
        add(6'h06, 0, 5, pk(6'h07, 6'h00, 6'h06, REP_D));
        add(6'h06, 0, 1, pk(6'h06, 6'h00, 6'h06, REP_D));
        add(6'h07, 0, 5, pk(6'h06, 6'h00, 6'h06, REP_D));
        add(6'h07, 0, 1, pk(6'h07, 6'h01, 6'h06, REP_D));
        add(6'h07, 1, 1, pk(6'h07, 6'h00, 6'h07, 6'h01));

        for (int r = 0; r < tbl.size(); r++) begin
            step($sformatf("tbl_row%0d", r), tbl[r].raw, tbl[r].tick, tbl[r].n, tbl[r].exp);
        end

        // asynchronous reset in the middle of debouncing 6'h3F
        step("pre_reset", 6'h3F, 0, 3, pk(6'h07, 6'h00, 6'h07, 6'h01));
        #3 rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        check("reset_async_immediate");
        @(posedge clk); #1;
        exp_q.push_back('0);
        check("reset_held");
        rst_n = 1'b1;
        step("post_reset_wait", 6'h3F, 0, 5, pk(6'h00, 6'h00, 6'h00, 6'h00));
        step("post_reset_rise", 6'h3F, 0, 1, pk(6'h3F, 6'h3F, 6'h00, 6'h00));

        // held ch0 across eight frames: auto-repeat pattern or single report
        rst_n = 1'b0; btn_raw = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("rep_wait", 6'h01, 0, 5, pk(6'h00, 6'h00, 6'h00, 6'h00));
        step("rep_rise", 6'h01, 0, 1, pk(6'h01, 6'h01, 6'h00, 6'h00));
        step("rep_idle", 6'h01, 0, 2, pk(6'h01, 6'h00, 6'h00, 6'h00));
        for (int t = 1; t <= 8; t++) begin
            logic [7:0] mask;
            logic [5:0] fr;
            mask = REP_MASK;
            fr   = {5'd0, mask[t-1]};
            step($sformatf("rep_tick%0d", t), 6'h01, 1, 1, pk(6'h01, 6'h00, 6'h01, fr));
            step($sformatf("rep_hold%0d", t), 6'h01, 0, 2, pk(6'h01, 6'h00, 6'h01, fr));
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
